// File: rtl/sw_count_ctrl.sv
// SPDT pushbutton debouncer with set/reset-latch semantics
// and a modulo-2^COUNT_W press counter, single clock domain.
module sw_count_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a,
  input  logic               b,
  input  logic               en,
  input  logic               clr,
  output logic               pressed,
  output logic               press_pulse,
  output logic               wrap,
  output logic               err,
  output logic               busy,
  output logic [COUNT_W-1:0] Q
);

  localparam int TW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] DB_LAST = TW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] T_ONE   = TW'(1);

  localparam logic [1:0] C_PRESS = 2'b01;
  localparam logic [1:0] C_REL   = 2'b10;
  localparam logic [1:0] C_ILL   = 2'b00;

  // bit1 = debounced level, bit0 = debouncing
  typedef enum logic [1:0] {
    REL      = 2'b00,
    DB_PRESS = 2'b01,
    HELD     = 2'b10,
    DB_REL   = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [TW-1:0]          timer_inc;
  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [COUNT_W-1:0]     q_q, q_d;
  logic [1:0]             code;
  logic                   q_inc;

  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b};
  end

  assign code      = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    press_pulse = 1'b0;
    err         = (code == C_ILL);
    unique case (state_q)
      REL: begin
        if (code == C_PRESS) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d     = HELD;
            press_pulse = 1'b1;
          end else begin
            state_d = DB_PRESS;
            timer_d = T_ONE;
          end
        end
      end
      DB_PRESS: begin
        if (code == C_PRESS) begin
          if (timer_inc == DB_LAST) begin
            state_d     = HELD;
            timer_d     = '0;
            press_pulse = 1'b1;
          end else begin
            timer_d = timer_inc;
          end
        end else if (code == C_REL) begin
          state_d = REL;
          timer_d = '0;
        end
      end
      HELD: begin
        if (code == C_REL) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = REL;
          end else begin
            state_d = DB_REL;
            timer_d = T_ONE;
          end
        end
      end
      DB_REL: begin
        if (code == C_REL) begin
          if (timer_inc == DB_LAST) begin
            state_d = REL;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end else if (code == C_PRESS) begin
          state_d = HELD;
          timer_d = '0;
        end
      end
    endcase
  end

  // clear wins over a coincident increment
  always_comb begin
    q_inc = press_pulse & en;
    wrap  = q_inc & ~clr & (q_q == {COUNT_W{1'b1}});
    q_d   = q_q;
    if (clr) begin
      q_d = '0;
    end else if (q_inc) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= REL;
      timer_q  <= '0;
      a_sync_q <= '1;
      b_sync_q <= '1;
      q_q      <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      q_q      <= q_d;
    end
  end

  assign pressed = state_q[1];
  assign busy    = state_q[0];
  assign Q       = q_q;

endmodule

// File: tb/tb_sw_count_ctrl.sv
// Bench for sw_count_ctrl: directed scenarios plus random
// contact traffic checked against a level/count reference model.
module tb_sw_count_ctrl;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int W  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a   = 1'b1;
  logic         b   = 1'b1;
  logic         en  = 1'b1;
  logic         clr = 1'b0;
  logic         pressed, press_pulse, wrap, err, busy;
  logic [W-1:0] Q;

  sw_count_ctrl #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .COUNT_W        (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .en         (en),
    .clr        (clr),
    .pressed    (pressed),
    .press_pulse(press_pulse),
    .wrap       (wrap),
    .err        (err),
    .busy       (busy),
    .Q          (Q)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // model: debounced level, qualifying samples so far, count
  int m_lvl, m_cnt, m_q;
  bit pa[SS];
  bit pb[SS];

  int dut_pulses = 0;
  int dut_wraps  = 0;
  int dut_errs   = 0;

  task automatic chk(string tag, int got, int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
  endtask

  task automatic m_reset();
    m_lvl = 0;
    m_cnt = 0;
    m_q   = 0;
    for (int i = 0; i < SS; i++) begin
      pa[i] = 1'b1;
      pb[i] = 1'b1;
    end
  endtask

  // drive inputs for the next edge, check this cycle, advance model
  task automatic apply(bit ai, bit bi, bit ei, bit ci);
    int code, tgt, opp;
    bit e_pulse, e_wrap;
    a = ai; b = bi; en = ei; clr = ci;
    #1;
    code    = pa[SS-1] * 2 + pb[SS-1];
    tgt     = m_lvl ? 2 : 1;
    opp     = m_lvl ? 1 : 2;
    e_pulse = (m_lvl == 0) && (code == 1) && (m_cnt + 1 == DB);
    e_wrap  = e_pulse && ei && !ci && (m_q == (1 << W) - 1);
    chk("pressed", int'(pressed), m_lvl);
    chk("busy", int'(busy), int'(m_cnt != 0));
    chk("press_pulse", int'(press_pulse), int'(e_pulse));
    chk("wrap", int'(wrap), int'(e_wrap));
    chk("err", int'(err), int'(code == 0));
    chk("Q", int'(Q), m_q);
    dut_pulses += int'(press_pulse);
    dut_wraps  += int'(wrap);
    dut_errs   += int'(err);
    if (ci) m_q = 0;
    else if (e_pulse && ei) m_q = (m_q + 1) % (1 << W);
    if (code == tgt) begin
      m_cnt++;
      if (m_cnt == DB) begin
        m_lvl = 1 - m_lvl;
        m_cnt = 0;
      end
    end else if (code == opp) begin
      m_cnt = 0;
    end
    for (int i = SS - 1; i > 0; i--) begin
      pa[i] = pa[i-1];
      pb[i] = pb[i-1];
    end
    pa[0] = ai;
    pb[0] = bi;
  endtask

  task automatic cyc(bit ai, bit bi, bit ei = 1, bit ci = 0);
    @(negedge clk);
    apply(ai, bi, ei, ci);
  endtask

  task automatic hold(bit ai, bit bi, int n,
                      bit ei = 1, bit ci = 0);
    repeat (n) cyc(ai, bi, ei, ci);
  endtask

  task automatic press_once(bit ei = 1, bit ci = 0);
    hold(1'b0, 1'b1, 7, ei, ci);
    hold(1'b1, 1'b0, 7, ei, ci);
  endtask

  task automatic do_reset(bit ai, bit bi);
    @(negedge clk);
    rst = 1'b1;
    a = ai; b = bi;
    #1;
    m_reset();
    chk("rst_Q", int'(Q), 0);
    chk("rst_pressed", int'(pressed), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulse", int'(press_pulse), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_wrap", int'(wrap), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(ai, bi, 1'b1, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, w0, e0, lat;
    int seq_a[6] = '{0, 1, 0, 1, 0, 0};
    int seq_b[6] = '{1, 1, 1, 1, 1, 1};
    m_reset();

    // clean press and release
    do_reset(1'b1, 1'b1);
    p0 = dut_pulses; e0 = dut_errs;
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    chk("clean_pulses", dut_pulses - p0, 1);
    chk("clean_Q", int'(Q), 1);
    chk("clean_err", dut_errs - e0, 0);

    // chatter 01/11/10, then a steady press
    do_reset(1'b1, 1'b1);
    p0 = dut_pulses;
    for (int i = 0; i < 20; i++) begin
      case (i % 3)
        0: cyc(1'b0, 1'b1);
        1: cyc(1'b1, 1'b1);
        default: cyc(1'b1, 1'b0);
      endcase
    end
    hold(1'b1, 1'b0, 3);
    chk("chatter_none", dut_pulses - p0, 0);
    hold(1'b0, 1'b1, 8);
    chk("chatter_pulses", dut_pulses - p0, 1);
    chk("chatter_Q", int'(Q), 1);

    // bounce through transit freezes the timer
    do_reset(1'b1, 1'b1);
    p0 = dut_pulses;
    for (int i = 0; i < 6; i++) cyc(seq_a[i][0], seq_b[i][0]);
    hold(1'b1, 1'b1, 4);
    chk("bounce_pulses", dut_pulses - p0, 1);
    chk("bounce_Q", int'(Q), 1);
    hold(1'b1, 1'b0, 8);

    // sixteen presses wrap the counter once
    do_reset(1'b1, 1'b1);
    w0 = dut_wraps;
    repeat (16) press_once();
    chk("wrap_count", dut_wraps - w0, 1);
    chk("wrap_Q", int'(Q), 0);
    repeat (3) press_once();
    p0 = dut_pulses; w0 = dut_wraps;
    press_once(1'b1, 1'b1);
    chk("clr_pulse", dut_pulses - p0, 1);
    chk("clr_Q", int'(Q), 0);
    chk("clr_wrap", dut_wraps - w0, 0);

    // enable low and an illegal code mid-debounce
    do_reset(1'b1, 1'b1);
    press_once();
    p0 = dut_pulses;
    press_once(1'b0, 1'b0);
    chk("en0_pulse", dut_pulses - p0, 1);
    chk("en0_Q", int'(Q), 1);
    e0 = dut_errs; p0 = dut_pulses;
    hold(1'b0, 1'b1, 3);
    cyc(1'b0, 1'b0);
    hold(1'b0, 1'b1, 8);
    chk("ill_err", dut_errs - e0, 1);
    chk("ill_pulse", dut_pulses - p0, 1);
    chk("ill_Q", int'(Q), 2);
    hold(1'b1, 1'b0, 8);

    // reset after two press samples
    do_reset(1'b1, 1'b1);
    hold(1'b0, 1'b1, 4);
    p0 = dut_pulses;
    do_reset(1'b0, 1'b1);
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      cyc(1'b0, 1'b1);
      if (press_pulse) lat = k + 1;
    end
    // lat is the cycle index after release holding the pulse
    chk("rst_latency", lat, SS + 4);
    chk("rst_single", dut_pulses - p0, 1);
    hold(1'b1, 1'b0, 8);

    // random contact traffic
    do_reset(1'b1, 1'b1);
    repeat (250) begin
      int r, len;
      bit ca, cb, ei;
      r = $urandom_range(0, 19);
      if (r < 8)       begin ca = 1'b0; cb = 1'b1; end
      else if (r < 16) begin ca = 1'b1; cb = 1'b0; end
      else if (r < 19) begin ca = 1'b1; cb = 1'b1; end
      else             begin ca = 1'b0; cb = 1'b0; end
      len = $urandom_range(1, 7);
      ei  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) do_reset(ca, cb);
      repeat (len) cyc(ca, cb, ei, ($urandom_range(0, 24) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
